ttc: RTL and testbench

//  Timing/trigger control decoder on the 40 MHz bunch clock. Takes the decoded TTC bits
//  BCR, ECR and L1A and maintains the bunch-crossing counter (BCID), orbit counter and

---
 rtl/ttc.sv | 122 ++++++++++++
 tb/tb_ttc.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttc.sv
// ttc: TTC decoder on the 40 MHz bunch clock.
// Tracks BCID, orbit and extended L1ID; emits tagged L1A strobes.
module ttc #(
  parameter int BCID_W     = 12,
  parameter int BCID_MAX   = 3564,
  parameter int BCR_OFFSET = 0,
  parameter int L1ID_W     = 24,
  parameter int ECR_W      = 8,
  parameter int ORBIT_W    = 32
) (
  input  logic               clk40,
  input  logic               rst,
  input  logic               ttc_bcr,
  input  logic               ttc_ecr,
  input  logic               ttc_l1a,
  output logic [BCID_W-1:0]  bcid,
  output logic               bcid_valid,
  output logic [ORBIT_W-1:0] orbit,
  output logic               l1a,
  output logic [BCID_W-1:0]  l1a_bcid,
  output logic [L1ID_W-1:0]  l1a_l1id,
  output logic [ECR_W-1:0]   l1a_ecr,
  output logic               bcr_err,
  output logic [15:0]        bcr_err_cnt
);

  localparam logic [BCID_W-1:0] LAST =
    BCID_W'(BCID_MAX - 1);
  localparam logic [BCID_W-1:0] OFFS =
    BCID_W'(BCR_OFFSET);

  logic              bcr_r;
  logic              ecr_r;
  logic              l1a_r;
  logic [L1ID_W-1:0] l1id;
  logic [L1ID_W-1:0] l1id_base;
  logic [ECR_W-1:0]  ecr_cnt;
  logic [ECR_W-1:0]  ecr_nx;
  logic              bcr_bad;

  // ECR lands before a same-cycle L1A is tagged
  always_comb begin
    l1id_base = l1id;
    ecr_nx    = ecr_cnt;
    if (ecr_r) begin
      l1id_base = '0;
      ecr_nx    = ecr_cnt + ECR_W'(1);
    end
  end

  // BCR is misaligned unless the orbit just ended
  always_comb begin
    bcr_bad = bcr_r && bcid_valid && (bcid != LAST);
  end

  // Register the decoded TTC bits once
  always_ff @(posedge clk40) begin
    if (!rst) begin
      bcr_r <= 1'b0;
      ecr_r <= 1'b0;
      l1a_r <= 1'b0;
    end else begin
      bcr_r <= ttc_bcr;
      ecr_r <= ttc_ecr;
      l1a_r <= ttc_l1a;
    end
  end

  // Bunch counter and orbit count
  always_ff @(posedge clk40) begin
    if (!rst) begin
      bcid       <= '0;
      bcid_valid <= 1'b0;
      orbit      <= '0;
    end else if (bcr_r) begin
      bcid       <= OFFS;
      bcid_valid <= 1'b1;
      orbit      <= orbit + ORBIT_W'(1);
    end else if (bcid_valid) begin
      if (bcid == LAST)
        bcid <= '0;
      else
        bcid <= bcid + BCID_W'(1);
    end
  end

  // Misaligned-BCR flag and saturating tally
  always_ff @(posedge clk40) begin
    if (!rst) begin
      bcr_err     <= 1'b0;
      bcr_err_cnt <= '0;
    end else begin
      bcr_err <= bcr_bad;
      if (bcr_bad && bcr_err_cnt != 16'hFFFF)
        bcr_err_cnt <= bcr_err_cnt + 16'd1;
    end
  end

  // Event counters and tagged L1A strobe
  always_ff @(posedge clk40) begin
    if (!rst) begin
      l1id     <= '0;
      ecr_cnt  <= '0;
      l1a      <= 1'b0;
      l1a_bcid <= '0;
      l1a_l1id <= '0;
      l1a_ecr  <= '0;
    end else begin
      l1a     <= l1a_r;
      ecr_cnt <= ecr_nx;
      if (l1a_r) begin
        l1id     <= l1id_base + L1ID_W'(1);
        l1a_bcid <= bcid;
        l1a_l1id <= l1id_base;
        l1a_ecr  <= ecr_nx;
      end else begin
        l1id <= l1id_base;
      end
    end
  end

endmodule

// File: tb/tb_ttc.sv
// tb_ttc: randomized bench for ttc against a
// behavioural TTC model (BCID_MAX=200).
module tb_ttc;

  localparam int NBC = 200;

  logic        clk40 = 1'b0;
  logic        rst = 1'b0;
  logic        ttc_bcr = 1'b0;
  logic        ttc_ecr = 1'b0;
  logic        ttc_l1a = 1'b0;
  logic [11:0] bcid;
  logic        bcid_valid;
  logic [31:0] orbit;
  logic        l1a;
  logic [11:0] l1a_bcid;
  logic [23:0] l1a_l1id;
  logic [7:0]  l1a_ecr;
  logic        bcr_err;
  logic [15:0] bcr_err_cnt;

  int checks = 0;
  int failures = 0;
  int ph = 0;
  bit auto_bcr = 1'b0;

  // model state
  int     m_bcid, m_l1id, m_ecr, m_errcnt;
  longint m_orbit;
  bit     m_valid;
  bit     m_bcr_r, m_ecr_r, m_l1a_r;
  bit     x_l1a, x_err;
  int     x_lbcid, x_ll1id, x_lecr;

  ttc #(
    .BCID_MAX(NBC),
    .BCR_OFFSET(0)
  ) dut (
    .clk40(clk40),
    .rst(rst),
    .ttc_bcr(ttc_bcr),
    .ttc_ecr(ttc_ecr),
    .ttc_l1a(ttc_l1a),
    .bcid(bcid),
    .bcid_valid(bcid_valid),
    .orbit(orbit),
    .l1a(l1a),
    .l1a_bcid(l1a_bcid),
    .l1a_l1id(l1a_l1id),
    .l1a_ecr(l1a_ecr),
    .bcr_err(bcr_err),
    .bcr_err_cnt(bcr_err_cnt)
  );

  always #5 clk40 = ~clk40;

  // Reference: one crossing of TTC behaviour
  always @(posedge clk40) begin
    if (!rst) begin
      m_bcid = 0; m_l1id = 0; m_ecr = 0;
      m_errcnt = 0; m_orbit = 0; m_valid = 0;
      m_bcr_r = 0; m_ecr_r = 0; m_l1a_r = 0;
      x_l1a = 0; x_err = 0;
      x_lbcid = 0; x_ll1id = 0; x_lecr = 0;
    end else begin
      x_l1a = 0;
      x_err = 0;
      if (m_ecr_r) begin
        m_l1id = 0;
        m_ecr = (m_ecr + 1) % 256;
      end
      if (m_l1a_r) begin
        x_l1a = 1;
        x_lbcid = m_bcid;
        x_ll1id = m_l1id;
        x_lecr = m_ecr;
        m_l1id = (m_l1id + 1) % (1 << 24);
      end
      if (m_bcr_r) begin
        if (m_valid && m_bcid != NBC - 1) begin
          x_err = 1;
          if (m_errcnt < 65535) m_errcnt++;
        end
        m_bcid = 0;
        m_valid = 1;
        m_orbit = (m_orbit + 1) % 64'h1_0000_0000;
      end else if (m_valid) begin
        m_bcid = (m_bcid + 1) % NBC;
      end
      m_bcr_r = ttc_bcr;
      m_ecr_r = ttc_ecr;
      m_l1a_r = ttc_l1a;
    end
  end

  // Drive one crossing, auto-BCR once per orbit
  task automatic tick(input bit b, input bit e,
                      input bit l);
    ttc_bcr = b | (auto_bcr && ph == 0);
    ttc_ecr = e;
    ttc_l1a = l;
    if (b) ph = 1;
    else if (auto_bcr) ph = (ph + 1) % NBC;
    @(negedge clk40);
  endtask

  task automatic wait_l1a(output bit ok);
    ok = 0;
    for (int k = 0; k < 4; k++) begin
      if (l1a) begin
        ok = 1;
        break;
      end
      tick(0, 0, 0);
    end
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (10) tick(0, 0, 0);
    checks++;
    if ({bcid, bcid_valid, orbit, l1a, l1a_bcid,
         l1a_l1id, l1a_ecr, bcr_err,
         bcr_err_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0",
        {bcid, bcid_valid, orbit, l1a, l1a_bcid,
         l1a_l1id, l1a_ecr, bcr_err, bcr_err_cnt});
    end
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0);
      checks++;
      if (bcid_valid !== 0 || bcid !== 0) begin
        failures++;
        $display("FAIL pre_bcr: valid=%0b bcid=%0d want 0/0",
          bcid_valid, bcid);
      end
    end
    tick(0, 0, 1);
    tick(0, 0, 0);
    checks++;
    if (l1a !== 1 || l1a_bcid !== 0 ||
        l1a_l1id !== 0 || l1a_ecr !== 0) begin
      failures++;
      $display("FAIL early_l1a: l1a=%0b bcid=%0d id=%0d ecr=%0d want 1/0/0/0",
        l1a, l1a_bcid, l1a_l1id, l1a_ecr);
    end
    tick(0, 0, 0);
    checks++;
    if (l1a !== 0) begin
      failures++;
      $display("FAIL l1a_width: got %0b want 0", l1a);
    end
  endtask

  task automatic test_bcid;
    auto_bcr = 1;
    ph = 0;
    for (int i = 0; i < 3 * NBC + 10; i++) begin
      tick(0, 0, 0);
      checks++;
      if (bcid !== 12'(m_bcid) ||
          bcid_valid !== m_valid ||
          orbit !== 32'(m_orbit) || bcr_err !== 0) begin
        failures++;
        $display("FAIL bcid_run: bcid=%0d v=%0b orb=%0d err=%0b want %0d/%0b/%0d/0",
          bcid, bcid_valid, orbit, bcr_err,
          m_bcid, m_valid, m_orbit);
      end
    end
    checks++;
    if (orbit !== 32'd4) begin
      failures++;
      $display("FAIL orbit_count: got %0d want 4", orbit);
    end
  endtask

  task automatic test_l1a;
    int n = 0;
    for (int i = 0; i < 400; i++) begin
      tick(0, 0, i % 61 == 0);
      if (l1a) n++;
      checks++;
      if (l1a !== x_l1a ||
          l1a_bcid !== 12'(x_lbcid) ||
          l1a_l1id !== 24'(x_ll1id) ||
          l1a_ecr !== 8'(x_lecr)) begin
        failures++;
        $display("FAIL l1a_tag: %0b/%0d/%0d/%0d want %0b/%0d/%0d/%0d",
          l1a, l1a_bcid, l1a_l1id, l1a_ecr,
          x_l1a, x_lbcid, x_ll1id, x_lecr);
      end
    end
    checks++;
    if (n != 7) begin
      failures++;
      $display("FAIL l1a_count: got %0d want 7", n);
    end
  endtask

  task automatic test_ecr;
    bit ok;
    tick(0, 1, 0);
    repeat (3) tick(0, 0, 0);
    tick(0, 0, 1);
    wait_l1a(ok);
    checks++;
    if (!ok || l1a_l1id !== 0 || l1a_ecr !== 1) begin
      failures++;
      $display("FAIL ecr_then_l1a: seen=%0b id=%0d ecr=%0d want 1/0/1",
        ok, l1a_l1id, l1a_ecr);
    end
    repeat (3) tick(0, 0, 0);
    tick(0, 1, 1);
    wait_l1a(ok);
    checks++;
    if (!ok || l1a_l1id !== 0 || l1a_ecr !== 2) begin
      failures++;
      $display("FAIL ecr_with_l1a: seen=%0b id=%0d ecr=%0d want 1/0/2",
        ok, l1a_l1id, l1a_ecr);
    end
    tick(0, 0, 0);
    tick(0, 0, 1);
    wait_l1a(ok);
    checks++;
    if (!ok || l1a_l1id !== 1 || l1a_ecr !== 2) begin
      failures++;
      $display("FAIL l1a_after_ecr: seen=%0b id=%0d ecr=%0d want 1/1/2",
        ok, l1a_l1id, l1a_ecr);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, i < 8);
      if (l1a) n++;
      checks++;
      if (l1a !== x_l1a ||
          l1a_l1id !== 24'(x_ll1id) ||
          l1a_bcid !== 12'(x_lbcid)) begin
        failures++;
        $display("FAIL b2b: l1a=%0b id=%0d bcid=%0d want %0b/%0d/%0d",
          l1a, l1a_l1id, l1a_bcid,
          x_l1a, x_ll1id, x_lbcid);
      end
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d want 8", n);
    end
  endtask

  task automatic test_bcr_err;
    int k = 0;
    while (!(m_valid && m_bcid == 56) && k < 400) begin
      tick(0, 0, 0);
      k++;
    end
    checks++;
    if (k >= 400) begin
      failures++;
      $display("FAIL bcr_err_setup: bcid 56 not reached got %0d", m_bcid);
    end
    tick(1, 0, 0);
    tick(0, 0, 0);
    checks++;
    if (bcr_err !== 1 || bcr_err_cnt !== 1 ||
        bcid !== 0) begin
      failures++;
      $display("FAIL bcr_err: err=%0b cnt=%0d bcid=%0d want 1/1/0",
        bcr_err, bcr_err_cnt, bcid);
    end
    tick(0, 0, 0);
    checks++;
    if (bcr_err !== 0 || bcr_err_cnt !== 1) begin
      failures++;
      $display("FAIL bcr_err_pulse: err=%0b cnt=%0d want 0/1",
        bcr_err, bcr_err_cnt);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(399) == 0,
           $urandom_range(24) == 0,
           $urandom_range(3) == 0);
      checks++;
      if (bcid !== 12'(m_bcid) ||
          bcid_valid !== m_valid ||
          orbit !== 32'(m_orbit) ||
          l1a !== x_l1a ||
          l1a_bcid !== 12'(x_lbcid) ||
          l1a_l1id !== 24'(x_ll1id) ||
          l1a_ecr !== 8'(x_lecr) ||
          bcr_err !== x_err ||
          bcr_err_cnt !== 16'(m_errcnt)) begin
        failures++;
        $display("FAIL random cyc %0d: %0d %0b %0d %0b %0d %0d %0d %0b %0d want %0d %0b %0d %0b %0d %0d %0d %0b %0d",
          i, bcid, bcid_valid, orbit, l1a, l1a_bcid,
          l1a_l1id, l1a_ecr, bcr_err, bcr_err_cnt,
          m_bcid, m_valid, m_orbit, x_l1a, x_lbcid,
          x_ll1id, x_lecr, x_err, m_errcnt);
      end
    end
  endtask

  task automatic test_mid_reset;
    int k = 0;
    while (m_bcid != 120 && k < 400) begin
      tick(0, 0, 1);
      k++;
    end
    rst = 0;
    tick(0, 0, 0);
    checks++;
    if ({bcid, bcid_valid, orbit, l1a, l1a_bcid,
         l1a_l1id, l1a_ecr, bcr_err,
         bcr_err_cnt} !== '0) begin
      failures++;
      $display("FAIL mid_reset: got %h want 0",
        {bcid, bcid_valid, orbit, l1a, l1a_bcid,
         l1a_l1id, l1a_ecr, bcr_err, bcr_err_cnt});
    end
    rst = 1;
    auto_bcr = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0);
      checks++;
      if (bcid_valid !== 0 || bcid !== 0) begin
        failures++;
        $display("FAIL post_reset: valid=%0b bcid=%0d want 0/0",
          bcid_valid, bcid);
      end
    end
    tick(1, 0, 0);
    tick(0, 0, 0);
    checks++;
    if (bcid_valid !== 1 || bcid !== 0 ||
        orbit !== 1) begin
      failures++;
      $display("FAIL rebcr: valid=%0b bcid=%0d orb=%0d want 1/0/1",
        bcid_valid, bcid, orbit);
    end
  endtask

  initial begin
    @(negedge clk40);
    test_reset();
    test_bcid();
    test_l1a();
    test_ecr();
    test_back_to_back();
    test_bcr_err();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
